// File: rtl/dcmac_0_rst_seq_pkg.sv
// Shared types and helpers for the DCMAC reset sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Holds the sequencer state encoding, the registered output bundle, the
// per-state counter width helper and the retry counter width.
package dcmac_0_rst_seq_pkg;

    // Encoding is exported on seq_state, so the values are fixed here.
    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_GT_WAIT = 3'd1,
        S_CORE    = 3'd2,
        S_TX      = 3'd3,
        S_RX_WAIT = 3'd4,
        S_DONE    = 3'd5,
        S_FAIL    = 3'd6
    } seq_state_e;

    localparam int               RETRY_W   = 4;
    localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

    // All registered status outputs, kept together so they are always
    // derived from one state value in one place.
    typedef struct packed {
        logic gt_reset;
        logic core_reset;
        logic tx_reset;
        logic rx_reset;
        logic seq_done;
        logic seq_fail;
    } seq_outs_t;

    localparam seq_outs_t SEQ_OUTS_RST = '{
        gt_reset: 1'b1, core_reset: 1'b1, tx_reset: 1'b1, rx_reset: 1'b1,
        seq_done: 1'b0, seq_fail: 1'b0
    };

    // Per-state counter width: wide enough for the longer of the two timeouts.
    function automatic int cnt_width(input int lock_to, input int align_to);
        int m;
        m = (lock_to > align_to) ? lock_to : align_to;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Resets are released cumulatively as the sequence advances; S_FAIL and
    // any unused encoding hold everything in reset.
    function automatic seq_outs_t outs_for(input seq_state_e s);
        seq_outs_t o;
        o = SEQ_OUTS_RST;
        case (s)
            S_GT_WAIT: begin
                o.gt_reset = 1'b0;
            end
            S_CORE: begin
                o.gt_reset   = 1'b0;
                o.core_reset = 1'b0;
            end
            S_TX: begin
                o.gt_reset   = 1'b0;
                o.core_reset = 1'b0;
                o.tx_reset   = 1'b0;
            end
            S_RX_WAIT: begin
                o.gt_reset   = 1'b0;
                o.core_reset = 1'b0;
                o.tx_reset   = 1'b0;
                o.rx_reset   = 1'b0;
            end
            S_DONE: begin
                o.gt_reset   = 1'b0;
                o.core_reset = 1'b0;
                o.tx_reset   = 1'b0;
                o.rx_reset   = 1'b0;
                o.seq_done   = 1'b1;
            end
            S_FAIL: begin
                o.seq_fail = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dcmac_0_rst_seq_sync.sv
// Multi-stage bit synchronizer for asynchronous status inputs.
// Latency: STAGES clk cycles from d_i change to q_o change.
// Backpressure: none; samples every cycle.
//
// Ports: clk, rst (async active-high, clears the chain to 0),
//        d_i (asynchronous input), q_o (synchronized output).
module dcmac_0_rst_seq_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dcmac_0_reset_sequencer.sv
// Power-up / recovery reset sequencer for the DCMAC: releases GT, core, TX, RX resets in order.
// Latency: all outputs registered; gt_lock/rx_aligned act SYNC_STAGES cycles after they change.
// Backpressure: none; soft_reset_req is a single-cycle pulse honoured in any state.
//
// Ports: clk, reset_async (async active-high), soft_reset_req, gt_lock and
//        rx_aligned (asynchronous status) in; gt_reset, core_reset, tx_reset,
//        rx_reset, seq_done, seq_fail, retry_cnt[3:0], seq_state[2:0] out.
// Build option: define DCMAC_0_RST_SEQ_RETRY_EN to retry after a timeout
// (up to MAX_RETRY); otherwise the first timeout goes straight to S_FAIL.
// HOLD_CYCLES and SETTLE_CYCLES must not exceed the larger timeout, since
// they share the per-state counter.
module dcmac_0_reset_sequencer
    import dcmac_0_rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES   = 64,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 1048576,
    parameter int ALIGN_TIMEOUT = 1048576,
    parameter int MAX_RETRY     = 3,
    parameter int SYNC_STAGES   = 3
) (
    input  logic               clk,
    input  logic               reset_async,
    input  logic               soft_reset_req,
    input  logic               gt_lock,
    input  logic               rx_aligned,
    output logic               gt_reset,
    output logic               core_reset,
    output logic               tx_reset,
    output logic               rx_reset,
    output logic               seq_done,
    output logic               seq_fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         seq_state
);

`ifdef DCMAC_0_RST_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int CNT_W = cnt_width(LOCK_TIMEOUT, ALIGN_TIMEOUT);

    // Timed states exit when the counter reaches N-1, giving exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ALIGN_LAST  = CNT_W'(ALIGN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    localparam logic [RETRY_W-1:0] MAX_RETRY_L = RETRY_W'(MAX_RETRY);

    logic gt_lock_s;
    logic rx_aligned_s;

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    seq_outs_t          outs_q;

    logic               lock_lost;
    logic               timed_out;
    logic [RETRY_W-1:0] retry_inc;

    dcmac_0_rst_seq_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk (clk),
        .rst (reset_async),
        .d_i (gt_lock),
        .q_o (gt_lock_s)
    );

    dcmac_0_rst_seq_sync #(.STAGES(SYNC_STAGES)) u_sync_align (
        .clk (clk),
        .rst (reset_async),
        .d_i (rx_aligned),
        .q_o (rx_aligned_s)
    );

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        lock_lost = !gt_lock_s &&
                    (state_q inside {S_CORE, S_TX, S_RX_WAIT, S_DONE});
        timed_out = ((state_q == S_GT_WAIT) && (cnt_q == LOCK_LAST)) ||
                    ((state_q == S_RX_WAIT) && (cnt_q == ALIGN_LAST));
        retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;

        // Priority: soft restart, lock loss, timeout, then normal progress.
        if (soft_reset_req) begin
            state_d = S_HOLD;
            retry_d = '0;
        end else if (lock_lost) begin
            state_d = S_HOLD;
        end else if (timed_out) begin
            retry_d = retry_inc;
            // The post-increment count decides whether another attempt is allowed.
            state_d = (RETRY_EN && (retry_inc < MAX_RETRY_L)) ? S_HOLD : S_FAIL;
        end else begin
            case (state_q)
                S_HOLD:    if (cnt_q == HOLD_LAST)   state_d = S_GT_WAIT;
                S_GT_WAIT: if (gt_lock_s)            state_d = S_CORE;
                S_CORE:    if (cnt_q == SETTLE_LAST) state_d = S_TX;
                S_TX:      if (cnt_q == SETTLE_LAST) state_d = S_RX_WAIT;
                S_RX_WAIT: if (rx_aligned_s)         state_d = S_DONE;
                // Alignment loss re-enters the wait with a fresh timeout.
                S_DONE:    if (!rx_aligned_s)        state_d = S_RX_WAIT;
                S_FAIL:    state_d = S_FAIL;
                default:   state_d = S_HOLD;
            endcase
        end

        // Counter restarts on every state entry, including S_HOLD re-entry
        // from a soft restart; it saturates rather than wrapping.
        if (soft_reset_req || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            retry_q <= '0;
            outs_q  <= SEQ_OUTS_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            // Outputs decoded from the next state so they switch with state_q.
            outs_q  <= outs_for(state_d);
        end
    end

    assign gt_reset   = outs_q.gt_reset;
    assign core_reset = outs_q.core_reset;
    assign tx_reset   = outs_q.tx_reset;
    assign rx_reset   = outs_q.rx_reset;
    assign seq_done   = outs_q.seq_done;
    assign seq_fail   = outs_q.seq_fail;
    assign retry_cnt  = retry_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_dcmac_0_reset_sequencer.sv
// Bench for dcmac_0_reset_sequencer: scoreboard of per-cycle expected outputs
// produced by a stage/dwell reference model, plus milestone checks taken from
// the sequencing timeline (cycle n = value seen after the n-th edge since
// reset release, first edge being cycle 0 of S_HOLD).
module tb_dcmac_0_reset_sequencer;

    localparam int HOLD     = 8;
    localparam int SETTLE   = 4;
    localparam int LOCK_TO  = 32;
    localparam int ALIGN_TO = 32;
    localparam int MAXR     = 2;
    localparam int SYNC     = 2;

`ifdef DCMAC_0_RST_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    // Stage indices in sequencing order; also the exported state encoding.
    localparam int M_HOLD = 0, M_GT_WAIT = 1, M_CORE = 2, M_TX = 3;
    localparam int M_RX_WAIT = 4, M_DONE = 5, M_FAIL = 6;

    logic       clk            = 1'b0;
    logic       reset_async    = 1'b1;
    logic       soft_reset_req = 1'b0;
    logic       gt_lock        = 1'b0;
    logic       rx_aligned     = 1'b0;
    logic       gt_reset, core_reset, tx_reset, rx_reset, seq_done, seq_fail;
    logic [3:0] retry_cnt;
    logic [2:0] seq_state;

    dcmac_0_reset_sequencer #(
        .HOLD_CYCLES   (HOLD),
        .SETTLE_CYCLES (SETTLE),
        .LOCK_TIMEOUT  (LOCK_TO),
        .ALIGN_TIMEOUT (ALIGN_TO),
        .MAX_RETRY     (MAXR),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk            (clk),
        .reset_async    (reset_async),
        .soft_reset_req (soft_reset_req),
        .gt_lock        (gt_lock),
        .rx_aligned     (rx_aligned),
        .gt_reset       (gt_reset),
        .core_reset     (core_reset),
        .tx_reset       (tx_reset),
        .rx_reset       (rx_reset),
        .seq_done       (seq_done),
        .seq_fail       (seq_fail),
        .retry_cnt      (retry_cnt),
        .seq_state      (seq_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       gt;
        logic       core;
        logic       tx;
        logic       rx;
        logic       done;
        logic       fail;
        logic [3:0] retry;
        logic [2:0] st;
    } obs_t;

    localparam obs_t RESET_OBS = '{gt: 1'b1, core: 1'b1, tx: 1'b1, rx: 1'b1,
                                   done: 1'b0, fail: 1'b0, retry: 4'd0, st: 3'd0};

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // ---------------- reference model ----------------
    int m_stage, m_t, m_retry;
    bit hist_l[$], hist_a[$];

    function automatic void model_reset();
        m_stage = M_HOLD;
        m_t     = 0;
        m_retry = 0;
        hist_l  = {};
        hist_a  = {};
        for (int i = 0; i < SYNC; i++) begin
            hist_l.push_back(1'b0);
            hist_a.push_back(1'b0);
        end
    endfunction

    // Dwell budget of each stage (0 = untimed).
    function automatic int dwell(input int s);
        case (s)
            M_HOLD:         return HOLD;
            M_GT_WAIT:      return LOCK_TO;
            M_CORE, M_TX:   return SETTLE;
            M_RX_WAIT:      return ALIGN_TO;
            default:        return 0;
        endcase
    endfunction

    function automatic void model_step(input bit lk, input bit al, input bit sr);
        bit ls, as, last;
        int nxt;
        hist_l.push_back(lk);
        hist_a.push_back(al);
        ls   = hist_l.pop_front();
        as   = hist_a.pop_front();
        nxt  = m_stage;
        last = (dwell(m_stage) > 0) && (m_t == dwell(m_stage) - 1);
        if (sr) begin
            nxt     = M_HOLD;
            m_retry = 0;
        end else if (!ls && m_stage >= M_CORE && m_stage <= M_DONE) begin
            nxt = M_HOLD;
        end else if (last && (m_stage == M_GT_WAIT || m_stage == M_RX_WAIT)) begin
            if (m_retry < 15) m_retry++;
            nxt = (RETRY_EN && m_retry < MAXR) ? M_HOLD : M_FAIL;
        end else begin
            case (m_stage)
                M_HOLD, M_CORE, M_TX: if (last) nxt = m_stage + 1;
                M_GT_WAIT:            if (ls)   nxt = M_CORE;
                M_RX_WAIT:            if (as)   nxt = M_DONE;
                M_DONE:               if (!as)  nxt = M_RX_WAIT;
                default: ;
            endcase
        end
        m_t     = (sr || nxt != m_stage) ? 0 : m_t + 1;
        m_stage = nxt;
    endfunction

    // Number of resets released grows with progress; failure holds all.
    function automatic obs_t model_obs();
        obs_t o;
        int   rel;
        rel     = (m_stage == M_FAIL) ? 0 : ((m_stage > 4) ? 4 : m_stage);
        o.gt    = (rel < 1);
        o.core  = (rel < 2);
        o.tx    = (rel < 3);
        o.rx    = (rel < 4);
        o.done  = (m_stage == M_DONE);
        o.fail  = (m_stage == M_FAIL);
        o.retry = 4'(m_retry);
        o.st    = 3'(m_stage);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o = {gt_reset, core_reset, tx_reset, rx_reset, seq_done, seq_fail, retry_cnt, seq_state};
        return o;
    endfunction

    // ---------------- milestones (recorded by the monitor) ----------------
    int rel = 0;
    int gt_fall, core_fall, tx_fall, rx_fall, done_at, fail_at, fail_retry;
    int drop_at, gt_rise, redone;

    function automatic void clear_marks();
        gt_fall = -1; core_fall = -1; tx_fall = -1; rx_fall = -1;
        done_at = -1; fail_at = -1; fail_retry = -1;
        drop_at = -1; gt_rise = -1; redone = -1;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (reset_async) rel = 0;
            else             rel++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_obs();
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard @%0t: got gt=%0b core=%0b tx=%0b rx=%0b done=%0b fail=%0b retry=%0d st=%0d, expected gt=%0b core=%0b tx=%0b rx=%0b done=%0b fail=%0b retry=%0d st=%0d",
                             $time, a.gt, a.core, a.tx, a.rx, a.done, a.fail, a.retry, a.st,
                             e.gt, e.core, e.tx, e.rx, e.done, e.fail, e.retry, e.st);
                end
            end
            if (!reset_async) begin
                if (!gt_reset   && gt_fall   < 0) gt_fall   = rel;
                if (!core_reset && core_fall < 0) core_fall = rel;
                if (!tx_reset   && tx_fall   < 0) tx_fall   = rel;
                if (!rx_reset   && rx_fall   < 0) rx_fall   = rel;
                if (seq_done    && done_at   < 0) done_at   = rel;
                if (seq_fail && fail_at < 0) begin
                    fail_at    = rel;
                    fail_retry = int'(retry_cnt);
                end
                if (drop_at >= 0 && gt_reset && gt_rise < 0) gt_rise = rel;
                if (gt_rise >= 0 && seq_done && redone < 0) redone = rel;
            end
        end
    end

    // Asynchronous reset must force reset values before any clock edge.
    initial begin
        #50;
        forever begin
            @(posedge reset_async);
            #1;
            vectors++;
            if (dut_obs() !== RESET_OBS) begin
                miscompares++;
                $display("FAIL async_reset @%0t: got %h, expected %h", $time, dut_obs(), RESET_OBS);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver ----------------
    task automatic step(input bit lk, input bit al, input bit sr, input bit ra);
        @(negedge clk);
        gt_lock        = lk;
        rx_aligned     = al;
        soft_reset_req = sr;
        reset_async    = ra;
        if (ra) model_reset();
        else    model_step(lk, al, sr);
        exp_q.push_back(model_obs());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit lk, al;
        model_reset();
        clear_marks();

        // Nominal bring-up: lock throughout, alignment from cycle 27.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) step(1'b1, (k >= 27), 1'b0, 1'b0);
        settle();
        chk("nominal gt_reset release", gt_fall, 8);
        chk("nominal core_reset release", core_fall, 9);
        chk("nominal tx_reset release", tx_fall, 13);
        chk("nominal rx_reset release", rx_fall, 17);
        chk("nominal seq_done", done_at, 30);

        // Lock loss in S_DONE: resets return within 3 cycles, then replay.
        drop_at = rel;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        chk("lock loss to gt_reset", gt_rise - drop_at, 3);
        chk("lock loss relink", redone - drop_at, 21);

        // Async reset in the middle of S_TX, then restart from S_HOLD.
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40 && m_stage != M_TX; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1);
        clear_marks();
        for (int k = 0; k < 25; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("restart gt_reset release", gt_fall, 8);
        chk("restart rx_reset release", rx_fall, 17);

        // No lock at all: timeouts until S_FAIL.
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        clear_marks();
        repeat (100) step(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("no-lock fail cycle", fail_at, RETRY_EN ? 80 : 40);
        chk("no-lock retry_cnt at fail", fail_retry, RETRY_EN ? 2 : 1);

        // Soft restart out of S_FAIL.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized lock/alignment flaps, soft restarts and async resets.
        lk = 1'b1;
        al = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (lk) begin
                if ($urandom_range(79) == 0) lk = 1'b0;
            end else if ($urandom_range(39) == 0) begin
                lk = 1'b1;
            end
            if (al) begin
                if ($urandom_range(49) == 0) al = 1'b0;
            end else if ($urandom_range(29) == 0) begin
                al = 1'b1;
            end
            if ($urandom_range(1499) == 0) begin
                repeat ($urandom_range(3, 1)) step(lk, al, 1'b0, 1'b1);
            end
            step(lk, al, ($urandom_range(299) == 0), 1'b0);
        end
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
